clock_recovery_ctrl: RTL and testbench
======================================

Name: clock_recovery_ctrl

Overview:
Digital loop controller for the clock recovery path. It consumes the up/down pulses from the phase detector and filters them through a signed accumulator. It issues single-step phase corrections to the recovered-clock oscillator as a code plus step strobes. A sequencing FSM (IDLE/ACQUIRE/TRACK/LOCKED) switches the loop gain and reports lock.

Parameters:
CODE_W, 6, width of the oscillator phase/frequency code
CODE_INIT, 32, dco_code value after reset
ACC_W, 4, signed accumulator width; TRK_THRESH must be < 2^(ACC_W-1)
ACQ_THRESH, 2, step threshold in ACQUIRE (high gain)
TRK_THRESH, 6, step threshold in TRACK and LOCKED (low gain)
WIN_LEN, 16, observation window length in clock cycles
LOCK_WINS, 4, consecutive quiet windows needed to declare lock

Ports:
clock  input  1  single system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
enable  input  1  loop enable; low forces IDLE
up  input  1  phase detector "early" indication, asynchronous to clock
down  input  1  phase detector "late" indication, asynchronous to clock
dco_code  output  CODE_W  oscillator control code
step_up  output  1  one-cycle pulse, dco_code incremented this cycle
step_dn  output  1  one-cycle pulse, dco_code decremented this cycle
locked  output  1  high while state == LOCKED
state  output  2  IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3

Behaviour:
- Reset values (async, immediate on reset_n low): dco_code=CODE_INIT, step_up=0, step_dn=0, locked=0, state=IDLE. Accumulator, window counter, quiet counter and window step count are all 0.
- up and down each pass through a 2-flop synchronizer, giving up_s and down_s.
- Per-cycle delta: +1 if up_s&~down_s; -1 if down_s&~up_s; 0 if both or neither.
- Threshold T: ACQ_THRESH in ACQUIRE; TRK_THRESH in TRACK and LOCKED.
- Accumulator (non-IDLE states only), with nxt = acc + delta:
  - nxt >= T: acc<=0, dco_code+1, step_up=1 on the next cycle.
  - nxt <= -T: acc<=0, dco_code-1, step_dn=1 on the next cycle.
  - Otherwise acc<=nxt.
- Saturation: dco_code saturates at 0 and 2^CODE_W-1. A blocked step still clears acc, produces no strobe, and sets the sat flag for that cycle.
- Window counter runs 0..WIN_LEN-1 in non-IDLE states and wraps. At wrap:
  - If the window step count is 0, quiet_cnt increments (saturating at LOCK_WINS).
  - Otherwise quiet_cnt<=0.
  - The window step count then clears.
  - A step in the wrap cycle counts toward the ending window.
- FSM transitions:
  - IDLE -> ACQUIRE when enable=1; acc, window and quiet counters restart from 0.
  - ACQUIRE -> TRACK at a window end where quiet_cnt becomes 1.
  - TRACK -> LOCKED at a window end where quiet_cnt reaches LOCK_WINS.
  - TRACK -> ACQUIRE on any sat event.
  - LOCKED -> TRACK at a window end whose step count is >= 2; quiet_cnt clears.
  - LOCKED -> ACQUIRE on any sat event.
  - Any state -> IDLE when enable=0, on the next edge. Accumulator and counters clear; dco_code holds its value.
- Simultaneous events: sat takes priority over window-end transitions; enable=0 takes priority over everything except reset.
- In IDLE, strobes are 0 and dco_code is frozen.
- Outputs are registered; locked is decoded from the state register.

Optional Feature:
CR_LOSS_COUNT_EN
- Defined: adds output port loss_cnt [7:0], reset 0. It increments (saturating at 255) on every LOCKED -> TRACK or LOCKED -> ACQUIRE transition, and holds its value through IDLE.
- Undefined: no port and no counter; all other behaviour is identical.

Test Plan:
- Reset: hold reset_n=0 with up=1 -> dco_code=32, state=0, locked=0, no strobes. Release reset_n with enable=0 -> outputs unchanged.
- Acquisition gain: enable=1, up=1 held -> first step_up 4 cycles after up rises (2 sync + 2 accumulate), then every 2 cycles; dco_code 33, 34, 35...; state stays 1.
- Lock: enable=1, up=down=0 -> state=2 after 16 cycles; state=3 and locked=1 after 64 cycles.
- Tracking gain and loss of lock: from LOCKED, assert down for 12 synchronized cycles -> two step_dn pulses spaced 6 cycles (e.g. dco_code 32->31->30). The next window end gives state=2 and locked=0; loss_cnt=1 if CR_LOSS_COUNT_EN is defined.
- Saturation: from TRACK, hold up until dco_code=63, then one more threshold crossing -> no step_up, dco_code stays 63, state=1.
- Disable/reset mid-operation: enable=0 during a step sequence -> state=0 next cycle, dco_code frozen. Assert reset_n=0 mid-cycle -> all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/clock_recovery_ctrl.sv
// clock_recovery_ctrl: phase-detector loop filter, DCO stepper and lock sequencer.
// Defining CR_LOSS_COUNT_EN adds the loss_cnt output (count of lock losses).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | loop disabled, counters cleared, dco_code frozen
// ACQUIRE | high gain (ACQ_THRESH), pulling in toward phase
// TRACK   | low gain (TRK_THRESH), counting quiet windows toward lock
// LOCKED  | low gain, lock reported; a busy window drops back to TRACK
module clock_recovery_ctrl #(
  parameter int CODE_W     = 6,
  parameter int CODE_INIT  = 32,
  parameter int ACC_W      = 4,
  parameter int ACQ_THRESH = 2,
  parameter int TRK_THRESH = 6,
  parameter int WIN_LEN    = 16,
  parameter int LOCK_WINS  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  output logic [CODE_W-1:0] dco_code,
  output logic              step_up,
  output logic              step_dn,
  output logic              locked,
  output logic [1:0]        state
`ifdef CR_LOSS_COUNT_EN
  ,
  output logic [7:0]        loss_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int SW      = ACC_W + 1;
  localparam int WIN_W   = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int QUIET_W = $clog2(LOCK_WINS + 1);
  localparam int STEPS_W = $clog2(WIN_LEN + 1);

  localparam logic signed [ACC_W:0] ACQ_T     = SW'(ACQ_THRESH);
  localparam logic signed [ACC_W:0] TRK_T     = SW'(TRK_THRESH);
  localparam logic [CODE_W-1:0]     CODE_MAX  = '1;
  localparam logic [CODE_W-1:0]     CODE_RST  = CODE_W'(CODE_INIT);
  localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(WIN_LEN - 1);
  localparam logic [QUIET_W-1:0]    QUIET_MAX = QUIET_W'(LOCK_WINS);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CODE_W-1:0]        code_q, code_d;
  logic                     step_up_q, step_up_d;
  logic                     step_dn_q, step_dn_d;
  logic [WIN_W-1:0]         win_q, win_d;
  logic [QUIET_W-1:0]       quiet_q, quiet_d;
  logic [STEPS_W-1:0]       steps_q, steps_d;
  logic                     up_meta_q, up_meta_d, up_s_q, up_s_d;
  logic                     dn_meta_q, dn_meta_d, dn_s_q, dn_s_d;
`ifdef CR_LOSS_COUNT_EN
  logic [7:0]               loss_q, loss_d;
`endif

  logic signed [ACC_W:0]    delta, nxt, thr;
  logic                     sat, stepped, win_end;
  logic [STEPS_W-1:0]       steps_cnt;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    code_d    = code_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;
    win_d     = win_q;
    quiet_d   = quiet_q;
    steps_d   = steps_q;
    up_meta_d = up;
    up_s_d    = up_meta_q;
    dn_meta_d = down;
    dn_s_d    = dn_meta_q;
`ifdef CR_LOSS_COUNT_EN
    loss_d    = loss_q;
`endif
    sat       = 1'b0;
    stepped   = 1'b0;
    win_end   = 1'b0;
    steps_cnt = steps_q;

    delta = '0;
    if (up_s_q && !dn_s_q)      delta = {{ACC_W{1'b0}}, 1'b1};
    else if (dn_s_q && !up_s_q) delta = '1;
    nxt = $signed({acc_q[ACC_W-1], acc_q}) + delta;
    thr = (state_q == ACQUIRE) ? ACQ_T : TRK_T;

    if (!enable) begin
      state_d = IDLE;
      acc_d   = '0;
      win_d   = '0;
      quiet_d = '0;
      steps_d = '0;
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
      acc_d   = '0;
      win_d   = '0;
      quiet_d = '0;
      steps_d = '0;
    end else begin
      // A step blocked at a code rail still consumes the accumulator.
      if (nxt >= thr) begin
        acc_d = '0;
        if (code_q != CODE_MAX) begin
          code_d    = code_q + 1'b1;
          step_up_d = 1'b1;
          stepped   = 1'b1;
        end else begin
          sat = 1'b1;
        end
      end else if (nxt <= -thr) begin
        acc_d = '0;
        if (code_q != '0) begin
          code_d    = code_q - 1'b1;
          step_dn_d = 1'b1;
          stepped   = 1'b1;
        end else begin
          sat = 1'b1;
        end
      end else begin
        acc_d = nxt[ACC_W-1:0];
      end

      steps_cnt = steps_q + STEPS_W'(stepped);
      if (win_q == WIN_LAST) begin
        win_end = 1'b1;
        win_d   = '0;
        steps_d = '0;
        if (steps_cnt == '0) quiet_d = (quiet_q == QUIET_MAX) ? quiet_q : quiet_q + 1'b1;
        else                 quiet_d = '0;
      end else begin
        win_d   = win_q + 1'b1;
        steps_d = steps_cnt;
      end

      unique case (state_q)
        ACQUIRE: begin
          if (!sat && win_end && steps_cnt == '0) state_d = TRACK;
        end
        TRACK: begin
          if (sat)                                  state_d = ACQUIRE;
          else if (win_end && quiet_d == QUIET_MAX) state_d = LOCKED;
        end
        LOCKED: begin
          if (sat)                                       state_d = ACQUIRE;
          else if (win_end && steps_cnt >= STEPS_W'(2)) state_d = TRACK;
`ifdef CR_LOSS_COUNT_EN
          if ((sat || (win_end && steps_cnt >= STEPS_W'(2))) && loss_q != 8'hFF)
            loss_d = loss_q + 8'd1;
`endif
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      code_q    <= CODE_RST;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
      win_q     <= '0;
      quiet_q   <= '0;
      steps_q   <= '0;
      up_meta_q <= 1'b0;
      up_s_q    <= 1'b0;
      dn_meta_q <= 1'b0;
      dn_s_q    <= 1'b0;
`ifdef CR_LOSS_COUNT_EN
      loss_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      code_q    <= code_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
      win_q     <= win_d;
      quiet_q   <= quiet_d;
      steps_q   <= steps_d;
      up_meta_q <= up_meta_d;
      up_s_q    <= up_s_d;
      dn_meta_q <= dn_meta_d;
      dn_s_q    <= dn_s_d;
`ifdef CR_LOSS_COUNT_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign dco_code = code_q;
  assign step_up  = step_up_q;
  assign step_dn  = step_dn_q;
  assign state    = state_q;
  assign locked   = (state_q == LOCKED);
`ifdef CR_LOSS_COUNT_EN
  assign loss_cnt = loss_q;
`endif

endmodule

// File: tb/tb_clock_recovery_ctrl.sv
// Scoreboard bench for clock_recovery_ctrl: stimulus queues expected output events
// (cycle, strobes, code, state); a negedge monitor pops and compares them.
module tb_clock_recovery_ctrl;

  logic       clock = 1'b0;
  logic       reset_n, enable, up, down;
  logic [5:0] dco_code;
  logic       step_up, step_dn, locked;
  logic [1:0] state;
`ifdef CR_LOSS_COUNT_EN
  logic [7:0] loss_cnt;
`endif

  clock_recovery_ctrl dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .enable   (enable),
    .up       (up),
    .down     (down),
    .dco_code (dco_code),
    .step_up  (step_up),
    .step_dn  (step_dn),
    .locked   (locked),
    .state    (state)
`ifdef CR_LOSS_COUNT_EN
    ,
    .loss_cnt (loss_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    int unsigned cyc;
    logic        su;
    logic        sd;
    logic [5:0]  code;
    logic [1:0]  st;
    logic        lk;
  } ev_t;

  ev_t         exp_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1:0]  prev_st = 2'd0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic push_ev(input int unsigned c, input logic su, input logic sd,
                         input int code, input int st);
    ev_t e;
    e.cyc  = c;
    e.su   = su;
    e.sd   = sd;
    e.code = 6'(code);
    e.st   = 2'(st);
    e.lk   = (st == 3);
    exp_q.push_back(e);
  endtask

  // Monitor: any strobe or state change is an output event.
  always @(negedge clock) begin
    ev_t a, e;
    if (!reset_n) begin
      prev_st = 2'd0;
    end else if (step_up || step_dn || state != prev_st) begin
      a.cyc  = cyc;
      a.su   = step_up;
      a.sd   = step_dn;
      a.code = dco_code;
      a.st   = state;
      a.lk   = locked;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: got cyc=%0d su=%0b sd=%0b code=%0d st=%0d lk=%0b, required none",
                 a.cyc, a.su, a.sd, a.code, a.st, a.lk);
      end else begin
        e = exp_q.pop_front();
        if (a != e) begin
          n_bad++;
          $display("FAIL event: got cyc=%0d su=%0b sd=%0b code=%0d st=%0d lk=%0b, required cyc=%0d su=%0b sd=%0b code=%0d st=%0d lk=%0b",
                   a.cyc, a.su, a.sd, a.code, a.st, a.lk, e.cyc, e.su, e.sd, e.code, e.st, e.lk);
        end
      end
      prev_st = state;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic check_outputs(input string name, input int code, input int st);
    check({name, "_code"},   int'(dco_code), code);
    check({name, "_state"},  int'(state),    st);
    check({name, "_locked"}, int'(locked),   (st == 3) ? 1 : 0);
    check({name, "_stepup"}, int'(step_up),  0);
    check({name, "_stepdn"}, int'(step_dn),  0);
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clock);
  endtask

  int unsigned t0, t1, t2, t3, t4;

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    up      = 1'b1;
    down    = 1'b0;
    repeat (3) @(negedge clock);
    check_outputs("rst_hold", 32, 0);
    reset_n = 1'b1;
    up      = 1'b0;
    repeat (4) @(negedge clock);
    check_outputs("rst_release", 32, 0);
`ifdef CR_LOSS_COUNT_EN
    check("loss_rst", int'(loss_cnt), 0);
`endif

    // Lock from quiet input: TRACK after one window, LOCKED after four.
    t1 = cyc;
    enable = 1'b1;
    push_ev(t1 + 1,  0, 0, 32, 1);
    push_ev(t1 + 17, 0, 0, 32, 2);
    push_ev(t1 + 65, 0, 0, 32, 3);
    wait_cyc(t1 + 65);

    // Twelve synchronized down cycles at low gain: two steps, then lock lost.
    t2 = cyc;
    down = 1'b1;
    push_ev(t2 + 8,  0, 1, 31, 3);
    push_ev(t2 + 14, 0, 1, 30, 3);
    push_ev(t2 + 16, 0, 0, 30, 2);
    wait_cyc(t2 + 12);
    down = 1'b0;
    wait_cyc(t2 + 16);
`ifdef CR_LOSS_COUNT_EN
    check("loss_after_unlock", int'(loss_cnt), 1);
`endif

    // Drive to the top rail; the next crossing is blocked and re-acquires.
    t3 = cyc;
    up = 1'b1;
    for (int i = 0; i < 33; i++) push_ev(t3 + 8 + 6 * i, 1, 0, 31 + i, 2);
    push_ev(t3 + 206, 0, 0, 63, 1);
    wait_cyc(t3 + 206);
    enable = 1'b0;
    up     = 1'b0;
    push_ev(t3 + 207, 0, 0, 63, 0);
    wait_cyc(t3 + 210);
    check_outputs("idle_frozen", 63, 0);
`ifdef CR_LOSS_COUNT_EN
    check("loss_hold_idle", int'(loss_cnt), 1);
`endif

    reset_n = 1'b0;
    #1;
    check_outputs("rst_from_idle", 32, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // High-gain acquisition, interrupted by enable=0, then resumed.
    t0 = cyc;
    enable = 1'b1;
    up     = 1'b1;
    push_ev(t0 + 1, 0, 0, 32, 1);
    push_ev(t0 + 4, 1, 0, 33, 1);
    push_ev(t0 + 6, 1, 0, 34, 1);
    push_ev(t0 + 8, 1, 0, 35, 1);
    wait_cyc(t0 + 9);
    enable = 1'b0;
    push_ev(t0 + 10, 0, 0, 35, 0);
    wait_cyc(t0 + 10);
    t4 = cyc;
    enable = 1'b1;
    push_ev(t4 + 1, 0, 0, 35, 1);
    push_ev(t4 + 3, 1, 0, 36, 1);
    push_ev(t4 + 5, 1, 0, 37, 1);
    wait_cyc(t4 + 5);

    // Asynchronous reset between edges, right after a step strobe.
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_outputs("async_rst", 32, 0);
    enable = 1'b0;
    up     = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_events: got %0d unseen, required 0 (next cyc=%0d)",
               exp_q.size(), exp_q[0].cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
